arb2: RTL and testbench
=======================

Name: arb2

Overview:
- N-input round-robin arbiter sharing one two-phase (transition-signalled) req/ack channel between N sources and a single downstream consumer, e.g. a sink2 endpoint.
- Detects pending source requests and grants one at a time.
- Forwards the granted source's data word downstream and returns the downstream acknowledge to that source.
- Sits between the traffic sources and the sink/router input port in the simpnoc fabric.

Parameters:
- ID, 0, instance number; for debug identification only.
- N, 4, number of requesting sources, 2..16.
- SIZE, 8, data word width in bits.
- CW, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_req  input  N  per-source two-phase request; source i is pending when in_req[i] != in_ack[i].
- in_ack  output  N  per-source two-phase acknowledge, registered.
- in_data  input  N*SIZE  source i word at bits [i*SIZE +: SIZE]; stable while source i is pending.
- out_req  output  1  downstream two-phase request, registered.
- out_ack  input  1  downstream two-phase acknowledge; transfer completes when out_ack == out_req.
- out_data  output  SIZE  latched word of the granted source, registered.
- grant  output  $clog2(N) (min 1)  index of the current or last granted source.
- busy  output  1  high in state WAIT.
- count  output  CW  number of completed transfers, wraps modulo 2^CW.

Behaviour:
- Single clock. Reset is asynchronous and active-high. All state is updated on posedge clk or posedge reset.
- Reset values: in_ack=0, out_req=0, out_data=0, grant=0, busy=0, count=0, state=IDLE. The round-robin pointer resets to N-1, so source 0 has first priority.
- pend[i] = in_req[i] ^ in_ack[i], computed from the current inputs and registered in_ack.
- State IDLE:
  - A grant requires |pend and out_req == out_ack. If out_req != out_ack in IDLE (spurious or late downstream ack), the arbiter stays in IDLE and issues nothing.
  - Selection: the first pending index searching ptr+1, ptr+2, … modulo N.
  - On grant, at the same edge: grant <= sel; out_data <= in_data[sel]; out_req <= ~out_req; state <= WAIT; busy <= 1.
- State WAIT:
  - Holds out_req, out_data and grant stable.
  - New source toggles are not sampled; they remain pending.
  - When out_ack == out_req, at the same edge: in_ack[grant] <= ~in_ack[grant]; ptr <= grant; count <= count+1; state <= IDLE; busy <= 0.
- Latency:
  - Source toggle to out_req toggle: 1 cycle when IDLE and the source wins.
  - out_ack toggle to in_ack toggle: 1 cycle.
  - The earliest next grant is the cycle after returning to IDLE, giving a minimum of 2 arbiter cycles per transfer plus downstream latency.
- Fairness: a source that was just served has lowest priority on the next grant. With all N sources continuously pending, grants rotate 0,1,…,N-1,0. No starvation.
- Simultaneous events:
  - Several sources toggling in the same cycle are resolved by round-robin.
  - A served source re-toggling in the same cycle its in_ack toggles is seen as pending in the next IDLE cycle and arbitrated normally.
- A source toggling in_req twice while pending is a protocol violation. Behaviour is undefined and is not checked.
- Reset mid-transfer: the block returns to reset values immediately. Sources and downstream must be reset together; no transfer is replayed.
- count wraps from 2^CW-1 to 0 with no flag.

Decomposition:
- Shared package arb2_pkg: state encoding constants ST_IDLE=1'b0, ST_WAIT=1'b1; a helper function computing the index width from N.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: pend[N], ptr.
  - Outputs: sel index and valid.
  - Used inside arb2. All state remains in arb2.

Test Plan:
- Reset then idle: reset high 3 cycles, no toggles → in_ack=0, out_req=0, count=0, busy=0; out_ack toggling in IDLE produces no grant.
- Single source: N=4. Toggle in_req[2] with in_data word2=8'hA5; sink2 attached downstream.
  - out_req toggles 1 cycle later with out_data=8'hA5 and grant=2.
  - After sink2's ack, in_ack[2] toggles 1 cycle later and count=1.
- All pending: toggle in_req[3:0] in the same cycle, with each source re-toggling on its ack, for 8 transfers → grant order 0,1,2,3,0,1,2,3; count=8.
- Back-to-back same source: source 1 re-toggles the cycle in_ack[1] toggles while source 3 is pending → next grant is 3, then 1.
- Slow downstream: hold out_ack for 20 cycles → busy=1 and out_req/out_data/grant stable throughout; a new source toggle during WAIT is served only after completion.
- Reset mid-WAIT: assert reset while busy=1 → all outputs return to reset values the same instant. After release, a pending source 0 is granted first.

Source files
------------

// File: rtl/arb2_pkg.sv
// Shared types and helpers for the arb2 round-robin arbiter.
package arb2_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Index width for an N-way selection, never less than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first pending index after i_ptr, modulo N.
module rr_pick
  import arb2_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_pend,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_sel,
  output logic          o_valid
);

  int w_idx;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_sel   = '0;
    o_valid = |i_pend;
    w_idx   = 0;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = N; k >= 1; k--) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (i_pend[w_idx]) o_sel = IW'(w_idx);
    end
  end

endmodule

// File: rtl/arb2.sv
// N-source round-robin arbiter onto one two-phase req/ack downstream channel.
module arb2
  import arb2_pkg::*;
#(
  parameter int ID   = 0,
  parameter int N    = 4,
  parameter int SIZE = 8,
  parameter int CW   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          in_req,
  output logic [N-1:0]          in_ack,
  input  logic [N*SIZE-1:0]     in_data,
  output logic                  out_req,
  input  logic                  out_ack,
  output logic [SIZE-1:0]       out_data,
  output logic [idx_w(N)-1:0]   grant,
  output logic                  busy,
  output logic [CW-1:0]         count
);

  localparam int IW = idx_w(N);

  // ID only tags the instance; it takes part in no logic.
  if (N < 2 || N > 16 || ID < 0) begin : g_param_check
    $error("arb2: N must be 2..16 and ID non-negative");
  end

  state_t          r_state;
  state_t          w_next_state;
  logic [N-1:0]    r_in_ack;
  logic            r_out_req;
  logic [SIZE-1:0] r_out_data;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;

  logic [N-1:0]    w_pend;
  logic [IW-1:0]   w_sel;
  logic            w_valid;
  logic            w_ds_idle;
  logic            w_do_grant;
  logic            w_do_done;

  assign w_pend    = in_req ^ r_in_ack;
  assign w_ds_idle = (r_out_req == out_ack);

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .i_pend  (w_pend),
    .i_ptr   (r_ptr),
    .o_sel   (w_sel),
    .o_valid (w_valid)
  );

  always_comb begin
    w_next_state = r_state;
    w_do_grant   = 1'b0;
    w_do_done    = 1'b0;
    case (r_state)
      // A stale downstream ack blocks new grants until the channel is balanced.
      ST_IDLE: if (w_valid && w_ds_idle) begin
        w_do_grant   = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: if (w_ds_idle) begin
        w_do_done    = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ack   <= '0;
      r_out_req  <= 1'b0;
      r_out_data <= '0;
      r_grant    <= '0;
      r_ptr      <= IW'(N - 1);
      r_count    <= '0;
    end else begin
      if (w_do_grant) begin
        r_grant    <= w_sel;
        r_out_data <= in_data[int'(w_sel)*SIZE +: SIZE];
        r_out_req  <= ~r_out_req;
      end
      if (w_do_done) begin
        r_in_ack[r_grant] <= ~r_in_ack[r_grant];
        r_ptr             <= r_grant;
        r_count           <= r_count + CW'(1);
      end
    end
  end

  assign in_ack   = r_in_ack;
  assign out_req  = r_out_req;
  assign out_data = r_out_data;
  assign grant    = r_grant;
  assign busy     = (r_state == ST_WAIT);
  assign count    = r_count;

endmodule

// File: tb/tb_arb2.sv
// Scoreboard bench for arb2 (N=4): expected grants queued at stimulus, checked at the sink.
module tb_arb2;

  localparam int N    = 4;
  localparam int SIZE = 8;
  localparam int CW   = 16;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] d;
  } exp_t;

  logic            clk;
  logic            reset;
  logic [N-1:0]    in_req;
  logic [N-1:0]    in_ack;
  logic [N*SIZE-1:0] in_data;
  logic            out_req;
  logic            out_ack;
  logic [SIZE-1:0] out_data;
  logic [1:0]      grant;
  logic            busy;
  logic [CW-1:0]   count;

  logic [7:0] words [N];
  exp_t       sb [$];
  int         n_pass;
  int         n_total;
  logic       exp_oreq;
  logic [CW-1:0] exp_count;

  assign in_data = {words[3], words[2], words[1], words[0]};

  arb2 #(.ID(0), .N(N), .SIZE(SIZE), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_req   (in_req),
    .in_ack   (in_ack),
    .in_data  (in_data),
    .out_req  (out_req),
    .out_ack  (out_ack),
    .out_data (out_data),
    .grant    (grant),
    .busy     (busy),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic do_reset();
    reset   = 1'b1;
    in_req  = '0;
    out_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset     = 1'b0;
    exp_oreq  = 1'b0;
    exp_count = '0;
    sb.delete();
    @(negedge clk);
  endtask

  // Downstream sink: waits for a request, pops the expected grant, acks after delay.
  task automatic sink_serve(input int delay, input bit retoggle, input int inj_src);
    exp_t e;
    int waited;
    logic [1:0] g;
    logic [7:0] d;
    logic ia;
    waited = 0;
    while (out_req === out_ack && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (out_req === out_ack) begin
      $display("FAIL grant_timeout: out_req=%b out_ack=%b after %0d cycles", out_req, out_ack, waited);
      return;
    end
    n_pass++;
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL unexpected_grant: grant=%0d with empty scoreboard", grant);
      return;
    end
    n_pass++;
    e = sb.pop_front();
    exp_oreq = ~exp_oreq;
    n_total++;
    if (grant !== e.g || out_data !== e.d || out_req !== exp_oreq || busy !== 1'b1)
      $display("FAIL grant_word: grant=%0d data=%h out_req=%b busy=%b, need grant=%0d data=%h out_req=%b busy=1",
               grant, out_data, out_req, busy, e.g, e.d, exp_oreq);
    else n_pass++;
    g  = grant;
    d  = out_data;
    ia = in_ack[e.g];
    for (int c = 0; c < delay; c++) begin
      if (c == 5 && inj_src >= 0) in_req[inj_src] = ~in_req[inj_src];
      @(negedge clk);
      n_total++;
      if (out_req !== exp_oreq || out_data !== d || grant !== g || busy !== 1'b1)
        $display("FAIL wait_stable: cycle %0d out_req=%b data=%h grant=%0d busy=%b, need %b %h %0d 1",
                 c, out_req, out_data, grant, busy, exp_oreq, d, g);
      else n_pass++;
    end
    out_ack = exp_oreq;
    @(negedge clk);
    exp_count++;
    n_total++;
    if (in_ack[e.g] !== ~ia || count !== exp_count || busy !== 1'b0)
      $display("FAIL complete: in_ack[%0d]=%b count=%0d busy=%b, need in_ack=%b count=%0d busy=0",
               e.g, in_ack[e.g], count, busy, ~ia, exp_count);
    else n_pass++;
    if (retoggle) in_req[e.g] = ~in_req[e.g];
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    in_req  = '0;
    out_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({in_ack, out_req, busy, count, grant, out_data} !== '0)
      $display("FAIL reset_held: in_ack=%b out_req=%b busy=%b count=%0d grant=%0d data=%h, need all 0",
               in_ack, out_req, busy, count, grant, out_data);
    else n_pass++;
    reset     = 1'b0;
    exp_oreq  = 1'b0;
    exp_count = '0;
    sb.delete();
    @(negedge clk);
    n_total++;
    if ({in_ack, out_req, busy, count} !== '0)
      $display("FAIL reset_idle: in_ack=%b out_req=%b busy=%b count=%0d, need all 0",
               in_ack, out_req, busy, count);
    else n_pass++;
    // Spurious downstream ack with a pending source: nothing may be issued.
    out_ack   = 1'b1;
    in_req[0] = 1'b1;
    sb.push_back('{2'd0, words[0]});
    repeat (3) @(negedge clk);
    n_total++;
    if (out_req !== 1'b0 || busy !== 1'b0)
      $display("FAIL spurious_ack: out_req=%b busy=%b, need 0 0", out_req, busy);
    else n_pass++;
    out_ack = 1'b0;
    sink_serve(0, 1'b0, -1);
  endtask

  task automatic test_single();
    in_req[2] = ~in_req[2];
    sb.push_back('{2'd2, 8'hA5});
    @(negedge clk);
    n_total++;
    if (out_req !== ~exp_oreq || grant !== 2'd2 || out_data !== 8'hA5)
      $display("FAIL single_latency: out_req=%b grant=%0d data=%h, need out_req=%b grant=2 data=a5",
               out_req, grant, out_data, ~exp_oreq);
    else n_pass++;
    sink_serve(2, 1'b0, -1);
  endtask

  task automatic test_all_pending();
    do_reset();
    in_req = ~in_req;
    for (int k = 0; k < 8; k++) sb.push_back('{2'(k % 4), words[k % 4]});
    for (int k = 0; k < 8; k++) sink_serve(k % 3, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_req[1] = ~in_req[1];
    in_req[3] = ~in_req[3];
    sb.push_back('{2'd1, words[1]});
    sb.push_back('{2'd3, words[3]});
    sb.push_back('{2'd1, words[1]});
    sink_serve(0, 1'b1, -1);
    sink_serve(1, 1'b0, -1);
    sink_serve(0, 1'b0, -1);
  endtask

  task automatic test_slow_downstream();
    do_reset();
    in_req[2] = ~in_req[2];
    sb.push_back('{2'd2, words[2]});
    sb.push_back('{2'd0, words[0]});
    sink_serve(20, 1'b0, 0);
    sink_serve(0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    do_reset();
    in_req[1] = ~in_req[1];
    sb.push_back('{2'd1, words[1]});
    @(negedge clk);
    e = sb.pop_front();
    n_total++;
    if (busy !== 1'b1 || grant !== e.g || out_data !== e.d)
      $display("FAIL pre_reset_grant: busy=%b grant=%0d data=%h, need 1 %0d %h", busy, grant, out_data, e.g, e.d);
    else n_pass++;
    #2;
    reset   = 1'b1;
    in_req  = '0;
    out_ack = 1'b0;
    #1;
    n_total++;
    if ({in_ack, out_req, busy, count, grant, out_data} !== '0)
      $display("FAIL reset_async: in_ack=%b out_req=%b busy=%b count=%0d grant=%0d data=%h, need all 0",
               in_ack, out_req, busy, count, grant, out_data);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    exp_oreq  = 1'b0;
    exp_count = '0;
    sb.delete();
    @(negedge clk);
    in_req[0] = 1'b1;
    in_req[2] = 1'b1;
    sb.push_back('{2'd0, words[0]});
    sb.push_back('{2'd2, words[2]});
    sink_serve(1, 1'b0, -1);
    sink_serve(0, 1'b0, -1);
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    exp_oreq  = 1'b0;
    exp_count = '0;
    words[0]  = 8'h11;
    words[1]  = 8'h22;
    words[2]  = 8'hA5;
    words[3]  = 8'h3C;
    reset     = 1'b1;
    in_req    = '0;
    out_ack   = 1'b0;
    test_reset();
    test_single();
    test_all_pending();
    test_back_to_back();
    test_slow_downstream();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
